// File: rtl/riscv_pkg.sv
// Types and constants shared by the pipeline stages of the RISC-V core.
package riscv_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] ROM_BASE     = 32'hBFC0_0000;
  localparam logic [31:0] ROM_LIMIT    = 32'hBFC0_0FFF;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
    logic        fault;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{
    instr:    NOP_INSTR,
    pc:       32'h0,
    pc_plus4: 32'h0,
    valid:    1'b0,
    fault:    1'b0
  };

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: reset or flush loads a bubble, stall holds, otherwise loads d_i.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   stall_i,
  input  logic   flush_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t if_id_q;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      if_id_q <= IF_ID_BUBBLE;
    end else if (!stall_i) begin
      if_id_q <= d_i;
    end
  end

  assign q_o = if_id_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and IF/ID capture.
// Optional fetch address checking is enabled by defining FETCH_RANGE_CHECK_EN.
module fetch_stage #(
  parameter int unsigned      DATA_WIDTH    = 32,
  parameter int unsigned      ADDRESS_WIDTH = 32,
  parameter logic [31:0]      RESET_VECTOR  = riscv_pkg::RESET_VECTOR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     StallF,
  input  logic                     StallD,
  input  logic                     FlushD,
  input  logic                     PCSrcE,
  input  logic [ADDRESS_WIDTH-1:0] PCTargetE,
  output logic [ADDRESS_WIDTH-1:0] PCF,
  input  logic [DATA_WIDTH-1:0]    InstrF,
  output logic [DATA_WIDTH-1:0]    InstrD,
  output logic [ADDRESS_WIDTH-1:0] PCD,
  output logic [ADDRESS_WIDTH-1:0] PCPlus4D,
  output logic                     ValidD,
  output logic                     FetchFaultD
);

  import riscv_pkg::*;

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  if_id_t      if_id_d, if_id_q;

  assign pc_plus4 = pc_q + 32'd4;

  // Redirect beats stall; reset is applied in the register itself.
  always_comb begin
    pc_d = pc_plus4;
    if (PCSrcE) begin
      pc_d = {PCTargetE[31:2], 2'b00};
    end else if (StallF) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

`ifdef FETCH_RANGE_CHECK_EN
  logic misalign_q;
  logic load;
  logic fault;

  assign load = !rst && !FlushD && !StallD;

  // Remembers a misaligned redirect until its target is first captured in IF/ID.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (PCSrcE) begin
      misalign_q <= |PCTargetE[1:0];
    end else if (load) begin
      misalign_q <= 1'b0;
    end
  end

  assign fault = (pc_q < ROM_BASE) || (pc_q > (ROM_LIMIT - 32'd3)) || misalign_q;

  always_comb begin
    if_id_d.instr    = fault ? NOP_INSTR : InstrF;
    if_id_d.pc       = pc_q;
    if_id_d.pc_plus4 = pc_plus4;
    if_id_d.valid    = 1'b1;
    if_id_d.fault    = fault;
  end
`else
  always_comb begin
    if_id_d.instr    = InstrF;
    if_id_d.pc       = pc_q;
    if_id_d.pc_plus4 = pc_plus4;
    if_id_d.valid    = 1'b1;
    if_id_d.fault    = 1'b0;
  end
`endif

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .stall_i (StallD),
    .flush_i (FlushD),
    .d_i     (if_id_d),
    .q_o     (if_id_q)
  );

  assign PCF         = pc_q;
  assign InstrD      = if_id_q.instr;
  assign PCD         = if_id_q.pc;
  assign PCPlus4D    = if_id_q.pc_plus4;
  assign ValidD      = if_id_q.valid;
  assign FetchFaultD = if_id_q.fault;

endmodule
